// File: rtl/linear_1d_pkg.sv
// Shared definitions for the linear_1d datapath: FSM encodings, packing helpers
// and the activation function codes used by the upstream activation stage.
package linear_1d_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_DRAIN    = 2'd2;
  localparam state_t ST_WAIT_OUT = 2'd3;

  typedef enum logic [2:0] {
    ACT_NONE       = 3'd0,
    ACT_RELU       = 3'd1,
    ACT_LEAKY_RELU = 3'd2,
    ACT_SIGMOID    = 3'd3,
    ACT_TANH       = 3'd4
  } activ_func_e;

  function automatic int pack_num(input int pack_width, input int data_width);
    return pack_width / data_width;
  endfunction

  function automatic int strb_width(input int width);
    return width / 8;
  endfunction

  // Lane index needs at least one bit even when a word holds a single element.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/linear_1d_output_packer.sv
// Packs the linear_1d output element stream into wide strobed words for the
// memory writer and checks the element count against the programmed LENGTH.
module linear_1d_output_packer
  import linear_1d_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = DATA_WIDTH / 8,
  parameter int PACK_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [LEN_WIDTH-1:0]    LENGTH,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR_LEN,
  output logic                    IN_READY,
  input  logic                    IN_VALID,
  input  logic [DATA_WIDTH-1:0]   IN_DATA,
  input  logic [USER_WIDTH-1:0]   IN_USER,
  input  logic                    IN_LAST,
  input  logic                    OUT_READY,
  output logic                    OUT_VALID,
  output logic [PACK_WIDTH-1:0]   OUT_DATA,
  output logic [PACK_WIDTH/8-1:0] OUT_STRB,
  output logic [USER_WIDTH-1:0]   OUT_USER,
  output logic                    OUT_LAST
);

  localparam int PACK_NUM  = pack_num(PACK_WIDTH, DATA_WIDTH);
  localparam int STRB_W    = strb_width(PACK_WIDTH);
  localparam int LANE_STRB = strb_width(DATA_WIDTH);
  localparam int IDX_W     = idx_width(PACK_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [PACK_WIDTH-1:0]  acc_q, acc_d;
  logic [STRB_W-1:0]      acc_strb_q, acc_strb_d;
  logic [USER_WIDTH-1:0]  acc_user_q, acc_user_d;
  logic                   ov_q, ov_d;
  logic [PACK_WIDTH-1:0]  odata_q, odata_d;
  logic [STRB_W-1:0]      ostrb_q, ostrb_d;
  logic [USER_WIDTH-1:0]  ouser_q, ouser_d;
  logic                   olast_q, olast_d;

  logic                   in_ready;
  logic                   in_beat;
  logic                   out_hs;
  logic [LEN_WIDTH-1:0]   cnt_inc;
  logic                   len_hit;
  logic                   end_vec;
  logic                   close_word;
  logic [PACK_WIDTH-1:0]  lane_data;
  logic [STRB_W-1:0]      lane_strb;
  logic [USER_WIDTH-1:0]  lane_user;

  // RUN stalls only while a finished word is still waiting; DRAIN swallows everything.
  assign in_ready = ((state_q == ST_RUN) && (!ov_q || OUT_READY)) || (state_q == ST_DRAIN);
  assign in_beat  = IN_VALID && in_ready;
  assign out_hs   = ov_q && OUT_READY;
  assign cnt_inc  = cnt_q + 1'b1;
  assign len_hit  = (cnt_inc == len_q);
  assign end_vec  = len_hit || IN_LAST;
  assign close_word = (idx_q == LAST_IDX) || end_vec;

  always_comb begin
    lane_data = acc_q;
    lane_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = IN_DATA;
    lane_strb = acc_strb_q;
    lane_strb[int'(idx_q)*LANE_STRB +: LANE_STRB] = {LANE_STRB{1'b1}};
    lane_user = (idx_q == '0) ? IN_USER : acc_user_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    done_d     = 1'b0;
    acc_d      = acc_q;
    acc_strb_d = acc_strb_q;
    acc_user_d = acc_user_q;
    ov_d       = ov_q;
    odata_d    = odata_q;
    ostrb_d    = ostrb_q;
    ouser_d    = ouser_q;
    olast_d    = olast_q;

    if (out_hs) begin
      ov_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          err_d = 1'b0;
          cnt_d = '0;
          idx_d = '0;
          len_d = LENGTH;
          if (LENGTH == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (in_beat) begin
          cnt_d = cnt_inc;
          if (close_word) begin
            ov_d       = 1'b1;
            odata_d    = lane_data;
            ostrb_d    = lane_strb;
            ouser_d    = lane_user;
            olast_d    = end_vec;
            acc_d      = '0;
            acc_strb_d = '0;
            acc_user_d = '0;
            idx_d      = '0;
            if (end_vec) begin
              // Exactly one of early-last or late-last means a length mismatch.
              err_d   = err_q || (IN_LAST != len_hit);
              state_d = (len_hit && !IN_LAST) ? ST_DRAIN : ST_WAIT_OUT;
            end
          end else begin
            acc_d      = lane_data;
            acc_strb_d = lane_strb;
            acc_user_d = lane_user;
            idx_d      = idx_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (in_beat && IN_LAST) begin
          state_d = ST_WAIT_OUT;
        end
      end

      ST_WAIT_OUT: begin
        // The last word may already have left while draining.
        if (!ov_q || OUT_READY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      acc_strb_q <= '0;
      acc_user_q <= '0;
      ov_q       <= 1'b0;
      odata_q    <= '0;
      ostrb_q    <= '0;
      ouser_q    <= '0;
      olast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      acc_strb_q <= acc_strb_d;
      acc_user_q <= acc_user_d;
      ov_q       <= ov_d;
      odata_q    <= odata_d;
      ostrb_q    <= ostrb_d;
      ouser_q    <= ouser_d;
      olast_q    <= olast_d;
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign ERR_LEN   = err_q;
  assign IN_READY  = in_ready;
  assign OUT_VALID = ov_q;
  assign OUT_DATA  = odata_q;
  assign OUT_STRB  = ostrb_q;
  assign OUT_USER  = ouser_q;
  assign OUT_LAST  = olast_q;

endmodule

// File: tb/tb_linear_1d_output_packer.sv
// Bench for linear_1d_output_packer: vector table plus hand-written reset and
// zero-length sequences, checked against a list-based packing model.
module tb_linear_1d_output_packer;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int PW = 128;
  localparam int LW = 16;
  localparam int PN = PW / DW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [LW-1:0] LENGTH = '0;
  logic          BUSY, DONE, ERR_LEN, IN_READY;
  logic          IN_VALID = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic [UW-1:0] IN_USER = '0;
  logic          IN_LAST = 1'b0;
  logic          OUT_READY = 1'b1;
  logic          OUT_VALID;
  logic [PW-1:0] OUT_DATA;
  logic [PW/8-1:0] OUT_STRB;
  logic [UW-1:0] OUT_USER;
  logic          OUT_LAST;

  linear_1d_output_packer #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .PACK_WIDTH(PW), .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .LENGTH(LENGTH),
    .BUSY(BUSY), .DONE(DONE), .ERR_LEN(ERR_LEN),
    .IN_READY(IN_READY), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_USER(IN_USER), .IN_LAST(IN_LAST),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_STRB(OUT_STRB), .OUT_USER(OUT_USER), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PW-1:0]   data;
    logic [PW/8-1:0] strb;
    logic [UW-1:0]   user;
    logic            last;
  } word_t;

  typedef struct {
    int          len;
    int          last_at;
    int          rmode;      // 0 always ready, 1 ten-cycle stall, 2 random
    bit          seq;        // data 1..N instead of random
    int          exp_words;
    bit          exp_err;
    logic [15:0] first_strb;
    logic [15:0] last_strb;
  } vec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  word_t mon_q[$];
  word_t exp_q[$];
  int    done_cnt = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    ready_mode = 0;
  bit    chk_inready = 1'b0;
  bit    prev_stall = 1'b0;
  logic [PW-1:0] prev_data;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      case (ready_mode)
        1:       OUT_READY = !((cyc - start_cyc >= 4) && (cyc - start_cyc < 14));
        2:       OUT_READY = ($urandom_range(0, 3) != 0);
        default: OUT_READY = 1'b1;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("out_valid_held", PW'(OUT_VALID), PW'(1'b1));
        chk("out_data_held", OUT_DATA, prev_data);
      end
      if (chk_inready && OUT_VALID && !OUT_READY)
        chk("in_ready_blocked", PW'(IN_READY), PW'(1'b0));
      if (OUT_VALID && OUT_READY)
        mon_q.push_back('{data: OUT_DATA, strb: OUT_STRB, user: OUT_USER, last: OUT_LAST});
      if (DONE) done_cnt++;
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
    end
  end

  // Drive one element and hold it until the packer takes it.
  task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input bit l);
    int t;
    bit took;
    IN_VALID = 1'b1; IN_DATA = d; IN_USER = u; IN_LAST = l;
    t = 0; took = 1'b0;
    while (!took && t < 200) begin
      @(negedge CLK);
      took = IN_READY;
      @(posedge CLK);
      #1;
      t++;
    end
    if (!took) chk("beat_timeout", PW'(0), PW'(1));
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    logic [DW-1:0] d[$];
    logic [UW-1:0] u[$];
    int end_i, t;
    for (int k = 0; k < v.last_at; k++) begin
      d.push_back(v.seq ? DW'(k + 1) : DW'($urandom));
      u.push_back(UW'($urandom_range(0, 15)));
    end
    // Reference: the vector covers min(LENGTH, position of LAST) elements, cut into PN-lane words.
    exp_q.delete();
    end_i = (v.len < v.last_at) ? v.len : v.last_at;
    for (int s = 0; s < end_i; s += PN) begin
      word_t w;
      int e;
      w = '{data: '0, strb: '0, user: '0, last: 1'b0};
      e = (s + PN < end_i) ? s + PN : end_i;
      for (int k = s; k < e; k++) begin
        w.data |= PW'(d[k]) << (DW * (k - s));
        w.strb |= 16'hF << (4 * (k - s));
      end
      w.user = u[s];
      w.last = (e == end_i);
      exp_q.push_back(w);
    end

    mon_q.delete();
    done_cnt    = 0;
    start_cyc   = cyc;
    ready_mode  = v.rmode;
    chk_inready = (v.last_at <= v.len);
    LENGTH = LW'(v.len); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    if (v.len != 0) chk("busy_after_start", PW'(BUSY), PW'(1'b1));
    @(posedge CLK); #1;
    if (v.len != 0) begin
      for (int k = 0; k < v.last_at; k++) begin
        if (v.rmode == 2) repeat ($urandom_range(0, 2)) @(posedge CLK);
        if (v.rmode == 2) #1;
        send_beat(d[k], u[k], k == v.last_at - 1);
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (done_cnt == 0) chk("done_timeout", PW'(0), PW'(1));
    repeat (3) @(negedge CLK);

    chk($sformatf("v%0d_word_count", idx), PW'(mon_q.size()), PW'(v.exp_words));
    chk($sformatf("v%0d_model_count", idx), PW'(mon_q.size()), PW'(exp_q.size()));
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("v%0d_w%0d_data", idx, i), mon_q[i].data, exp_q[i].data);
      chk($sformatf("v%0d_w%0d_strb", idx, i), PW'(mon_q[i].strb), PW'(exp_q[i].strb));
      chk($sformatf("v%0d_w%0d_user", idx, i), PW'(mon_q[i].user), PW'(exp_q[i].user));
      chk($sformatf("v%0d_w%0d_last", idx, i), PW'(mon_q[i].last), PW'(exp_q[i].last));
    end
    if (mon_q.size() > 0) begin
      chk($sformatf("v%0d_first_strb", idx), PW'(mon_q[0].strb), PW'(v.first_strb));
      chk($sformatf("v%0d_last_strb", idx), PW'(mon_q[mon_q.size()-1].strb), PW'(v.last_strb));
    end
    chk($sformatf("v%0d_err_len", idx), PW'(ERR_LEN), PW'(v.exp_err));
    chk($sformatf("v%0d_done_count", idx), PW'(done_cnt), PW'(1));
    chk($sformatf("v%0d_busy_end", idx), PW'(BUSY), PW'(1'b0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, PW'(OUT_VALID), PW'(0));
    chk({tag, "_out_data"}, OUT_DATA, PW'(0));
    chk({tag, "_out_strb"}, PW'(OUT_STRB), PW'(0));
    chk({tag, "_out_last"}, PW'(OUT_LAST), PW'(0));
    chk({tag, "_busy"}, PW'(BUSY), PW'(0));
    chk({tag, "_done"}, PW'(DONE), PW'(0));
    chk({tag, "_err"}, PW'(ERR_LEN), PW'(0));
    chk({tag, "_in_ready"}, PW'(IN_READY), PW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{8,  8,  0, 1, 2, 0, 16'hFFFF, 16'hFFFF};
    tbl[1]  = '{5,  5,  0, 1, 2, 0, 16'hFFFF, 16'h000F};
    tbl[2]  = '{6,  3,  0, 1, 1, 1, 16'h0FFF, 16'h0FFF};
    tbl[3]  = '{4,  6,  0, 1, 1, 1, 16'hFFFF, 16'hFFFF};
    tbl[4]  = '{12, 12, 1, 1, 3, 0, 16'hFFFF, 16'hFFFF};
    tbl[5]  = '{0,  0,  0, 1, 0, 0, 16'h0000, 16'h0000};
    tbl[6]  = '{9,  9,  2, 0, 3, 0, 16'hFFFF, 16'h000F};
    tbl[7]  = '{7,  2,  2, 0, 1, 1, 16'h00FF, 16'h00FF};
    tbl[8]  = '{3,  10, 2, 0, 1, 1, 16'h0FFF, 16'h0FFF};
    tbl[9]  = '{1,  1,  2, 0, 1, 0, 16'h000F, 16'h000F};
    tbl[10] = '{16, 16, 2, 0, 4, 0, 16'hFFFF, 16'hFFFF};
    tbl[11] = '{4,  4,  1, 0, 1, 0, 16'hFFFF, 16'hFFFF};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK); #1;

    for (int i = 0; i < 12; i++) begin
      run_vector(tbl[i], i);
      if (i == 0 && mon_q.size() == 2) begin
        chk("normal_w0_literal", mon_q[0].data, 128'h00000004_00000003_00000002_00000001);
        chk("normal_w1_literal", mon_q[1].data, 128'h00000008_00000007_00000006_00000005);
      end
      if (i == 1 && mon_q.size() == 2)
        chk("partial_w1_literal", mon_q[1].data, 128'h00000000_00000000_00000000_00000005);
      @(posedge CLK); #1;
    end

    // Abort a vector after three beats; nothing of it may surface later.
    ready_mode = 0;
    mon_q.delete();
    done_cnt = 0;
    LENGTH = LW'(8); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(32'hDEAD_0000 | DW'(k), 4'hA, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("midreset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("midreset_no_done", PW'(done_cnt), PW'(0));
    chk("midreset_no_words", PW'(mon_q.size()), PW'(0));
    @(posedge CLK); #1;
    run_vector('{4, 4, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF}, 20);
    if (mon_q.size() == 1)
      chk("after_reset_literal", mon_q[0].data, 128'h00000004_00000003_00000002_00000001);
    run_vector('{2, 2, 0, 1, 1, 0, 16'h00FF, 16'h00FF}, 21);

    // Zero length: DONE on the cycle right after START is sampled.
    @(posedge CLK); #1;
    mon_q.delete();
    LENGTH = '0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("zero_len_done", PW'(DONE), PW'(1));
    chk("zero_len_busy", PW'(BUSY), PW'(0));
    @(negedge CLK);
    chk("zero_len_done_pulse", PW'(DONE), PW'(0));
    repeat (5) @(negedge CLK);
    chk("zero_len_no_words", PW'(mon_q.size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
